// File: rtl/disp_pkg.sv
//------------------------------------------------------------------------------
// Module      : disp_pkg
// Description : Shared constants and types for the 7-segment scan controller:
//               display mode encodings, blank patterns, digit-slot indices and
//               a helper that turns a slot index into an active-low anode word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  // Display mode encodings
  localparam logic [1:0] MODE_TIMER = 2'b00;
  localparam logic [1:0] MODE_TEMP  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // Idle pin patterns (everything active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Digit-slot positions on the 8-digit display
  localparam logic [2:0] IDX_SEC0  = 3'd0;
  localparam logic [2:0] IDX_SEC1  = 3'd1;
  localparam logic [2:0] IDX_MIN0  = 3'd2;
  localparam logic [2:0] IDX_MIN1  = 3'd3;
  localparam logic [2:0] IDX_TEMP0 = 3'd6;
  localparam logic [2:0] IDX_TEMP1 = 3'd7;
  localparam logic [2:0] IDX_LAST  = 3'd7;

  // Content selected for the slot currently being scanned
  typedef struct packed {
    logic       mapped;  // slot has content in the active mode
    logic       timer;   // content is a timer digit (subject to blinking)
    logic [6:0] seg;     // active-low segment pattern
  } slot_src_t;

  // Active-low one-hot anode word for a slot index
  function automatic logic [7:0] an_for_idx(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
//------------------------------------------------------------------------------
// Module      : scan_tick_gen
// Description : Digit-slot tick counter. Counts 0..DIGIT_TICKS-1 and wraps.
// Ports       : clk_100MHz - system clock
//               rst_n      - synchronous active-low reset
//               cnt_o      - current position inside the slot
//               wrap_o     - high on the last cycle of the slot (count wraps
//                            at the next edge)
//               guard_o    - high once the anti-ghosting guard is over
//                            (cnt_o >= GUARD_TICKS)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_tick_gen #(
  parameter int DIGIT_TICKS = 100000,
  parameter int GUARD_TICKS = 16,
  parameter int CNT_W       = 17
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             guard_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == CNT_LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero-length guard would make the compare trivially true, so it is
  // tied off instead of building a comparator against zero.
  generate
    if (GUARD_TICKS == 0) begin : g_no_guard
      assign guard_o = 1'b1;
    end else begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_TICKS);
      assign guard_o = (cnt_q >= GUARD_END);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : display_scan_ctrl
// Description : Scan scheduler for an 8-digit common-anode 7-segment display.
//               Time-multiplexes timer and temperature digit patterns onto the
//               shared anode/segment/DP pins, selects content by display mode,
//               blanks the start of every slot against ghosting, blinks the
//               timer digits on request and flags frame boundaries.
// Ports       : clk_100MHz        - system clock
//               rst_n             - synchronous active-low reset
//               display_sec_D0/D1 - seconds units/tens (active-low segments)
//               display_min_D0/D1 - minutes units/tens
//               display_temp_D0/D1- temperature units/tens
//               mode              - 00 timer, 01 temp, 10 both, 11 blank
//               blink_en          - blink the timer digits
//               AN                - anode enables, active-low, one-cold
//               display           - segment drive, active-low
//               DP                - decimal point, active-low
//               frame_done        - one-cycle pulse after each 8-digit frame
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGIT_TICKS  = 100000,
  parameter int GUARD_TICKS  = 16,
  parameter int BLINK_FRAMES = 31
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [6:0] display_sec_D0,
  input  logic [6:0] display_sec_D1,
  input  logic [6:0] display_min_D0,
  input  logic [6:0] display_min_D1,
  input  logic [6:0] display_temp_D0,
  input  logic [6:0] display_temp_D1,
  input  logic [1:0] mode,
  input  logic       blink_en,
  output logic [7:0] AN,
  output logic [6:0] display,
  output logic       DP,
  output logic       frame_done
);

  localparam int CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Slot timing
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_wrap;
  logic             tick_guard;

  // Scan / mode / blink state
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       mode_act_q, mode_act_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  // Output registers
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;

  slot_src_t        src;
  logic             timer_on;
  logic             frame_end;
  logic             drive;

  scan_tick_gen #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .GUARD_TICKS (GUARD_TICKS),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .cnt_o      (tick_cnt),
    .wrap_o     (tick_wrap),
    .guard_o    (tick_guard)
  );

  // Last cycle of the last slot: the whole frame wraps at the next edge.
  assign frame_end = (tick_cnt == CNT_LAST) && (idx_q == IDX_LAST);

  //--------------------------------------------------------------------------
  // Scan position, frame-synchronous mode and blink state
  //--------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    mode_act_d  = mode_act_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (tick_wrap) begin
      idx_d = idx_q + 3'd1;  // 7 -> 0 by natural overflow
    end

    // Mode only changes between frames so a frame is never mixed.
    if (frame_end) begin
      mode_act_d = mode;
    end

    if (!blink_en) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Digit map: which input (if any) belongs on the current slot
  //--------------------------------------------------------------------------
  assign timer_on = (mode_act_q == MODE_TIMER) || (mode_act_q == MODE_BOTH);

  always_comb begin
    src = '{mapped: 1'b0, timer: 1'b0, seg: SEG_BLANK};
    case (idx_q)
      IDX_SEC0: begin
        if (timer_on) begin
          src = '{mapped: 1'b1, timer: 1'b1, seg: display_sec_D0};
        end else if (mode_act_q == MODE_TEMP) begin
          // Temperature-only mode reuses the two rightmost digits.
          src = '{mapped: 1'b1, timer: 1'b0, seg: display_temp_D0};
        end
      end
      IDX_SEC1: begin
        if (timer_on) begin
          src = '{mapped: 1'b1, timer: 1'b1, seg: display_sec_D1};
        end else if (mode_act_q == MODE_TEMP) begin
          src = '{mapped: 1'b1, timer: 1'b0, seg: display_temp_D1};
        end
      end
      IDX_MIN0: begin
        if (timer_on) begin
          src = '{mapped: 1'b1, timer: 1'b1, seg: display_min_D0};
        end
      end
      IDX_MIN1: begin
        if (timer_on) begin
          src = '{mapped: 1'b1, timer: 1'b1, seg: display_min_D1};
        end
      end
      IDX_TEMP0: begin
        if (mode_act_q == MODE_BOTH) begin
          src = '{mapped: 1'b1, timer: 1'b0, seg: display_temp_D0};
        end
      end
      IDX_TEMP1: begin
        if (mode_act_q == MODE_BOTH) begin
          src = '{mapped: 1'b1, timer: 1'b0, seg: display_temp_D1};
        end
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Pin drive decision. Blinking only ever hides timer digits.
  //--------------------------------------------------------------------------
  assign drive = tick_guard && src.mapped &&
                 !(src.timer && blink_en && blink_ph_q);

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    fd_d  = frame_end;
    if (drive) begin
      an_d  = an_for_idx(idx_q);
      seg_d = src.seg;
      // Colon substitute between minutes and seconds.
      if (src.timer && (idx_q == IDX_MIN0)) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      mode_act_q  <= MODE_TIMER;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      mode_act_q  <= mode_act_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign AN         = an_q;
  assign display    = seg_q;
  assign DP         = dp_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl with a cycle-level
//               behavioural model of the scan rules and directed + random
//               stimulus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_display_scan_ctrl;

  localparam int DT = 8;
  localparam int GT = 2;
  localparam int BF = 2;
  localparam int FR = 8 * DT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] sec0, sec1, min0, min1, temp0, temp1;
  logic [1:0] mode;
  logic       blink_en;
  logic [7:0] AN;
  logic [6:0] display;
  logic       DP;
  logic       frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIGIT_TICKS  (DT),
    .GUARD_TICKS  (GT),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk_100MHz      (clk),
    .rst_n           (rst_n),
    .display_sec_D0  (sec0),
    .display_sec_D1  (sec1),
    .display_min_D0  (min0),
    .display_min_D1  (min1),
    .display_temp_D0 (temp0),
    .display_temp_D1 (temp1),
    .mode            (mode),
    .blink_en        (blink_en),
    .AN              (AN),
    .display         (display),
    .DP              (DP),
    .frame_done      (frame_done)
  );

  //--------------------------------------------------------------------------
  // Behavioural model: time since reset gives slot and position directly;
  // the blink phase is the parity of completed blink periods.
  //--------------------------------------------------------------------------
  int         m_t;
  int         m_n;
  int         m_idx;
  int         m_cnt;
  logic [1:0] m_mode;
  logic [6:0] m_seg;
  bit         m_map, m_tmr, m_on;
  bit         m_valid = 1'b0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      m_t = 0; m_n = 0; m_mode = 2'b00;
    end else begin
      m_idx = (m_t / DT) % 8;
      m_cnt = m_t % DT;
      m_seg = 7'h7F; m_map = 1'b0; m_tmr = 1'b0;
      if (m_mode == 2'b00 || m_mode == 2'b10) begin
        m_tmr = (m_idx <= 3);
        m_map = m_tmr;
        case (m_idx)
          0: m_seg = sec0;
          1: m_seg = sec1;
          2: m_seg = min0;
          3: m_seg = min1;
          default: ;
        endcase
      end
      if (m_mode == 2'b01 && m_idx <= 1) begin
        m_map = 1'b1;
        m_seg = (m_idx == 0) ? temp0 : temp1;
      end
      if (m_mode == 2'b10 && m_idx >= 6) begin
        m_map = 1'b1;
        m_seg = (m_idx == 6) ? temp0 : temp1;
      end
      m_on  = (m_cnt >= GT) && m_map && !(m_tmr && blink_en && ((m_n / BF) % 2 == 1));
      e_an  = m_on ? ~(8'd1 << m_idx) : 8'hFF;
      e_seg = m_on ? m_seg : 7'h7F;
      e_dp  = !(m_on && m_tmr && m_idx == 2);
      e_fd  = ((m_t % FR) == FR - 1);
      if (e_fd) m_mode = mode;
      if (!blink_en) m_n = 0;
      else if (e_fd) m_n = m_n + 1;
      m_t = m_t + 1;
    end
    m_valid = 1'b1;
  end

  //--------------------------------------------------------------------------
  // Checking helpers (all comparisons happen in the single stimulus process)
  //--------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("AN", int'(AN), int'(e_an));
      chk("display", int'(display), int'(e_seg));
      chk("DP", int'(DP), int'(e_dp));
      chk("frame_done", int'(frame_done), int'(e_fd));
    end
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      tick();
      k++;
    end while (frame_done !== 1'b1 && k < 4 * FR);
    chk("frame_sync_timeout", int'(frame_done === 1'b1), 1);
  endtask

  task automatic expect_restart(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (AN !== 8'hFE && k < 20);
    chk(name, k, 3);
  endtask

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    int n_fd, n_dp, n_dpbad, n_a, n_b, n_c;

    rst_n    = 1'b0;
    mode     = 2'b00;
    blink_en = 1'b0;
    min1 = 7'b1111001; min0 = 7'b0100100;
    sec1 = 7'b0110000; sec0 = 7'b0011001;
    temp1 = 7'b0010010; temp0 = 7'b1000000;

    // Reset state
    repeat (3) tick();
    chk("rst_AN", int'(AN), 'hFF);
    chk("rst_display", int'(display), 'h7F);
    chk("rst_DP", int'(DP), 1);
    chk("rst_frame_done", int'(frame_done), 0);

    // Release: first driven digit after the guard, showing sec_D0
    rst_n = 1'b1;
    expect_restart("first_FE_latency");
    chk("first_digit_sec0", int'(display), 'b0011001);

    // Timer mode over two frames
    n_fd = 0; n_dp = 0; n_dpbad = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (frame_done) n_fd++;
      if (!DP) begin
        n_dp++;
        if (AN != 8'hFB) n_dpbad++;
      end
    end
    chk("timer_frame_pulses", n_fd, 2);
    chk("timer_dp_cycles", n_dp, 12);
    chk("timer_dp_outside_FB", n_dpbad, 0);

    // Mode 00 -> 01 during idx2: current frame keeps timer
    wait_frame();
    repeat (20) tick();
    mode = 2'b01;
    n_a = 0;
    for (int i = 0; i < FR - 20; i++) begin
      tick();
      if (AN == 8'hF7 && display == 7'b1111001) n_a++;
    end
    chk("modechg_min1_kept", n_a, 6);
    n_a = 0; n_b = 0; n_c = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (AN == 8'hFB || AN == 8'hF7) n_a++;
      if (AN == 8'hFE && display == 7'b1000000) n_b++;
      if (AN == 8'hFD && display == 7'b0010010) n_c++;
    end
    chk("temp_no_min_digits", n_a, 0);
    chk("temp_D0_on_FE", n_b, 6);
    chk("temp_D1_on_FD", n_c, 6);

    // Mode 10: timer plus temperature on the two leftmost digits
    mode = 2'b10;
    wait_frame();
    n_a = 0; n_b = 0; n_c = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (AN == 8'hBF) n_a++;
      if (AN == 8'h7F) n_b++;
      if (AN == 8'hFE) n_c++;
    end
    chk("both_BF_cycles", n_a, 6);
    chk("both_7F_cycles", n_b, 6);
    chk("both_FE_cycles", n_c, 6);

    // Mode 11: all blank, frames still marked
    mode = 2'b11;
    wait_frame();
    n_a = 0; n_fd = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (AN != 8'hFF) n_a++;
      if (frame_done) n_fd++;
    end
    chk("off_anodes_active", n_a, 0);
    chk("off_frame_pulses", n_fd, 2);

    // Blink: frames 0-1 visible, 2-3 blank, release mid-frame 2
    mode = 2'b00;
    wait_frame();
    wait_frame();
    blink_en = 1'b1;
    n_a = 0; n_b = 0;
    for (int k = 1; k <= 2 * FR + 20; k++) begin
      tick();
      if (AN != 8'hFF) begin
        if (k <= 2 * FR) n_a++;
        else n_b++;
      end
    end
    chk("blink_visible_frames", n_a, 48);
    chk("blink_hidden_frames", n_b, 0);
    blink_en = 1'b0;
    tick();
    chk("blink_release_AN", int'(AN), 'hFB);
    chk("blink_release_seg", int'(display), 'b0100100);
    chk("blink_release_DP", int'(DP), 0);

    // Reset during idx5 with blink phase set and a pending mode change
    blink_en = 1'b1;
    wait_frame();
    wait_frame();
    repeat (5 * DT + 3) tick();
    mode  = 2'b01;
    rst_n = 1'b0;
    tick();
    chk("midrst_AN", int'(AN), 'hFF);
    chk("midrst_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;
    expect_restart("midrst_restart_latency");
    chk("midrst_first_digit", int'(display), 'b0011001);

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: sec0  = 7'($urandom);
          1: sec1  = 7'($urandom);
          2: min0  = 7'($urandom);
          3: min1  = 7'($urandom);
          4: temp0 = 7'($urandom);
          default: temp1 = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
